// File: rtl/q_pkg.sv
// Shared types and constants for the Q-learning TD(0) update unit.
// Holds datapath widths, the Q-value ceiling and the update FSM state enum.
// Imported by q_td_calc and q_update_unit.
package q_pkg;

  localparam int Q_W   = 18;  // Q-value width (unsigned)
  localparam int ACT_W = 4;   // action index width
  localparam int TD_W  = 20;  // signed width of target / delta

  localparam logic [Q_W-1:0] Q_MAX = 18'h3FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WT   = 3'd2,
    CALC = 3'd3,
    WR   = 3'd4
  } upd_state_e;

endpackage

// File: rtl/q_td_calc.sv
// TD(0) arithmetic: gq = gamma*maxq >> GAMMA_W, target, delta, alpha shift, clamp to [0, Q_MAX].
// Latency: purely combinational, no state.
// Backpressure: none; the caller samples q_new_o when it needs it.
// Ports: reward_i (signed r), max_q_i, gamma_i, terminal_i, q_old_i -> q_new_o (clamped).
// Build option: Q_UPD_ROUND_EN selects round-half-up on the alpha shift instead of floor.
module q_td_calc
  import q_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_W     = 8
) (
  input  logic signed [Q_W-1:0]     reward_i,
  input  logic        [Q_W-1:0]     max_q_i,
  input  logic        [GAMMA_W-1:0] gamma_i,
  input  logic                      terminal_i,
  input  logic        [Q_W-1:0]     q_old_i,
  output logic        [Q_W-1:0]     q_new_o
);

  localparam int PROD_W = Q_W + GAMMA_W;

  logic        [PROD_W-1:0] prod;
  logic        [Q_W-1:0]    gq;
  logic signed [TD_W-1:0]   target;
  logic signed [TD_W-1:0]   delta;
  logic signed [TD_W:0]     delta_x;
  logic signed [TD_W:0]     step;
  logic signed [TD_W:0]     q_sum;

  assign prod = PROD_W'(max_q_i) * PROD_W'(gamma_i);
  // Discarding the GAMMA_W fraction bits truncates; the result always fits in Q_W bits.
  assign gq   = Q_W'(prod >> GAMMA_W);

  assign target = terminal_i ? TD_W'(reward_i)
                             : TD_W'(reward_i) + $signed(TD_W'(gq));
  // target in [-2^17, 2^17-1 + 2^18-1], q_old in [0, 2^18-1]: delta fits in 20 signed bits.
  assign delta  = target - $signed(TD_W'(q_old_i));

`ifdef Q_UPD_ROUND_EN
  localparam int RND = 1 << (ALPHA_SHIFT - 1);
  // Extra bit so the rounding bias can never overflow before the shift.
  assign delta_x = (TD_W+1)'(delta) + (TD_W+1)'(RND);
`else
  assign delta_x = (TD_W+1)'(delta);
`endif

  assign step  = delta_x >>> ALPHA_SHIFT;
  assign q_sum = $signed({3'b000, q_old_i}) + step;

  // Saturate at both ends; wrap-around would corrupt the table.
  always_comb begin
    q_new_o = q_sum[Q_W-1:0];
    if (q_sum < 0) begin
      q_new_o = '0;
    end else if (q_sum > $signed({3'b000, Q_MAX})) begin
      q_new_o = Q_MAX;
    end
  end

endmodule

// File: rtl/q_update_unit.sv
// Q-table TD(0) updater: read Q(s,a), apply r + gamma*maxQ(s') update, write back.
// Latency: transfer at edge T -> read in cycle T+1, write + done in T+4, ready again in T+5.
// Backpressure: upd_ready_o is high only in IDLE; valid while busy is ignored, no capture.
// Ports: upd_valid_i/upd_ready_o request handshake with state_i, action_i, reward_i, max_q_i,
//        terminal_i, gamma_i; Q-table side q_rd_en_o, q_addr_o, q_rd_data_i (1-cycle latency),
//        q_wr_en_o, q_wr_data_o; done_o pulses with the write.
// Build option: Q_UPD_ROUND_EN (see q_td_calc) selects rounded alpha shift.
module q_update_unit
  import q_pkg::*;
#(
  parameter int SW          = 15,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid_i,
  output logic                    upd_ready_o,
  input  logic [SW-1:0]           state_i,
  input  logic [ACT_W-1:0]        action_i,
  input  logic signed [Q_W-1:0]   reward_i,
  input  logic [Q_W-1:0]          max_q_i,
  input  logic                    terminal_i,
  input  logic [GAMMA_W-1:0]      gamma_i,
  output logic                    q_rd_en_o,
  output logic [SW+ACT_W-1:0]     q_addr_o,
  input  logic [Q_W-1:0]          q_rd_data_i,
  output logic                    q_wr_en_o,
  output logic [Q_W-1:0]          q_wr_data_o,
  output logic                    done_o
);

  upd_state_e state_q, state_d;

  logic [SW-1:0]         st_q;
  logic [ACT_W-1:0]      act_q;
  logic signed [Q_W-1:0] reward_q;
  logic [Q_W-1:0]        max_q_q;
  logic                  terminal_q;
  logic [GAMMA_W-1:0]    gamma_q;
  logic [Q_W-1:0]        q_old_q;
  logic [Q_W-1:0]        q_new_q;
  logic [Q_W-1:0]        q_new_w;
  logic                  xfer;

  assign xfer = upd_valid_i && upd_ready_o;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (upd_valid_i) state_d = RD;
      RD:      state_d = WT;
      WT:      state_d = CALC;
      CALC:    state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state alone, so async reset drops the strobes immediately.
  always_comb begin
    upd_ready_o = (state_q == IDLE);
    q_rd_en_o   = (state_q == RD);
    q_wr_en_o   = (state_q == WR);
    done_o      = (state_q == WR);
  end

  // Request capture and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= '0;
      act_q      <= '0;
      reward_q   <= '0;
      max_q_q    <= '0;
      terminal_q <= 1'b0;
      gamma_q    <= '0;
      q_old_q    <= '0;
      q_new_q    <= '0;
    end else begin
      if (xfer) begin
        st_q       <= state_i;
        act_q      <= action_i;
        reward_q   <= reward_i;
        max_q_q    <= max_q_i;
        terminal_q <= terminal_i;
        gamma_q    <= gamma_i;
      end
      // RAM data is valid in the cycle after the read strobe, i.e. while in WT.
      if (state_q == WT) begin
        q_old_q <= q_rd_data_i;
      end
      if (state_q == CALC) begin
        q_new_q <= q_new_w;
      end
    end
  end

  q_td_calc #(
    .ALPHA_SHIFT (ALPHA_SHIFT),
    .GAMMA_W     (GAMMA_W)
  ) u_td_calc (
    .reward_i   (reward_q),
    .max_q_i    (max_q_q),
    .gamma_i    (gamma_q),
    .terminal_i (terminal_q),
    .q_old_i    (q_old_q),
    .q_new_o    (q_new_w)
  );

  // Address comes straight from the captured request, so it is stable RD..WR.
  assign q_addr_o    = {st_q, act_q};
  assign q_wr_data_o = q_new_q;

endmodule

// File: doc/q_update_unit.md
Name: q_update_unit

Overview:
- Downstream consumer of the 9-input max-Q reducer in the tic-tac-toe Q-learning datapath.
- Takes max_a' Q(s',a') from the reducer, plus reward, state, action and terminal flag for the transition just played.
- Reads Q(s,a) from the Q-table RAM, applies the TD(0) update, and writes the result back.
- Multi-cycle FSM with a valid/ready request handshake and a done pulse.

Parameters:
- SW, 15, state index width (3^9 = 19683 board states).
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT; legal range 1..8.
- GAMMA_W, 8, width of the discount input; gamma = gamma_i / 2^GAMMA_W.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- upd_valid_i, input, 1, update request valid.
- upd_ready_o, output, 1, high only in IDLE.
- state_i, input, SW, current state s.
- action_i, input, 4, action a; values 0..8 are used.
- reward_i, input, 18, signed reward r.
- max_q_i, input, 18, unsigned max Q of next state (reducer output).
- terminal_i, input, 1, s' is terminal, so the bootstrap term is dropped.
- gamma_i, input, GAMMA_W, unsigned discount fraction.
- q_rd_en_o, output, 1, Q-table read strobe.
- q_addr_o, output, SW+4, Q-table address {state, action}; shared by read and write.
- q_rd_data_i, input, 18, read data, valid exactly one cycle after q_rd_en_o.
- q_wr_en_o, output, 1, Q-table write strobe.
- q_wr_data_o, output, 18, updated Q(s,a).
- done_o, output, 1, one-cycle pulse coincident with q_wr_en_o.

Behaviour:
- Reset values: FSM = IDLE; q_rd_en_o, q_wr_en_o, done_o = 0; q_addr_o, q_wr_data_o = 0. Because reset is asynchronous, the strobes drop immediately, even in the middle of a transaction.
- Handshake: a transfer occurs on the edge where upd_valid_i && upd_ready_o. All inputs are captured into registers on that edge. Input changes after the capture have no effect.
- States and transitions:
  - IDLE -> RD on a transfer.
  - RD -> WT unconditionally; q_rd_en_o = 1 in RD.
  - WT -> CALC; q_old is latched from q_rd_data_i at the end of WT.
  - CALC -> WR; q_new is registered.
  - WR -> IDLE; q_wr_en_o = 1 and done_o = 1 in WR.
- Latency and throughput: with the transfer at edge T, the read is in cycle T+1, the write and done in cycle T+4, and ready is high again in cycle T+5. Throughput is one update per 5 cycles.
- q_addr_o holds {state, action} from RD through WR.
- Arithmetic:
  - gq = (gamma_i * max_q_i) >> GAMMA_W, truncated, unsigned 18 bits.
  - target = terminal ? r : r + gq, signed 20 bits.
  - delta = target - q_old, signed 20 bits; cannot overflow.
  - q_new = q_old + (delta >>> ALPHA_SHIFT), signed 21 bits.
  - q_new is clamped to [0, 262143].
- Saturation: clamping at both bounds is mandatory. Wrap-around is forbidden.
- Actions 9..15 are not checked. They are read and written like any other action.
- upd_valid_i asserted while not IDLE is ignored: no capture, no stall error.

Optional Feature:
- Macro: Q_UPD_ROUND_EN.
- Defined: the alpha shift rounds half-up, i.e. (delta + 2^(ALPHA_SHIFT-1)) >>> ALPHA_SHIFT.
- Undefined: plain arithmetic shift (floor).
- Latency, ports and clamping are identical in both builds.

Decomposition:
- Package q_pkg holds:
  - Q_W = 18, ACT_W = 4, TD_W = 20;
  - the FSM state enum (IDLE, RD, WT, CALC, WR);
  - the Q_MAX = 18'h3FFFF constant.
- One sub-module, q_td_calc: combinational gq/target/delta/shift/clamp, instantiated once in the CALC stage. It takes the alpha shift as a parameter and honours Q_UPD_ROUND_EN.

Test Plan:
- Nominal update:
  - Stimulus: ALPHA_SHIFT=2, gamma=230, q_old=1000, max_q=2000, r=100, non-terminal.
  - Response: gq=1796, target=1896; write 1224 at T+4 with done_o; ready returns at T+5.
- Terminal, low clamp:
  - Stimulus: q_old=1000, r=-4000, terminal=1, max_q=262143.
  - Response: max_q is ignored and the write is 0 (raw value -250).
- High clamp:
  - Stimulus: q_old=262000, r=131071, max_q=262143, gamma=255.
  - Response: gq=261118, write 262143.
- Rounding:
  - Stimulus: q_old=1000, r=995, terminal (delta=-5).
  - Response: write 998 without Q_UPD_ROUND_EN, 999 with it.
- Handshake and timing:
  - Stimulus: back-to-back valid; inputs changed in cycle T+2; valid held during the busy period.
  - Response: only the first request is captured, q_addr_o is stable RD..WR, and the second request is accepted at T+5. Verify q_addr_o={state,action} and that q_rd_en_o and q_wr_en_o each pulse exactly one cycle.
- Reset mid-write:
  - Stimulus: rst_n low during WR.
  - Response: q_wr_en_o and done_o fall asynchronously and the FSM returns to IDLE. After release, ready=1 and a new update completes normally.
